// File: rtl/gshare_bht_pkg.sv
// gshare_bht_pkg: configuration, shared types and helper functions for the
// gshare/bimodal branch history table.
//   - table geometry (rows, banks, counter width, history length)
//   - request/response structs carried on gshare_bht_if
//   - saturating counter helpers and the predict-time row hash
package gshare_bht_pkg;

   localparam int VLEN            = 32;
   localparam int INSTR_PER_FETCH = 2;
   localparam bit RVC             = 1'b1;
   localparam int NR_ENTRIES      = 1024;
   localparam int CTR_BITS        = 2;
   localparam int HIST_BITS       = 4;

   localparam int NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int ROW_BITS = $clog2(NR_ROWS);
   localparam int BANK_W   = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
   // lowest pc bit that selects a fetch slot: halfwords with C, words without
   localparam int BANK_LSB = RVC ? 1 : 2;
   localparam int ROW_LSB  = $clog2(INSTR_PER_FETCH) + BANK_LSB;
   // keep a 1-bit history register when history is disabled; it stays zero
   localparam int GHR_W    = (HIST_BITS > 0) ? HIST_BITS : 1;

   typedef logic [CTR_BITS-1:0] ctr_t;
   typedef logic [ROW_BITS-1:0] row_t;
   typedef logic [GHR_W-1:0]    ghr_t;
   typedef logic [BANK_W-1:0]   bank_t;

   localparam ctr_t INIT_VAL = ctr_t'((1 << (CTR_BITS-1)) - 1);  // weakly not-taken
   localparam ctr_t CTR_MAX  = '1;

   typedef enum logic {INIT, IDLE} init_state_e;

   typedef struct packed {
      row_t index;
   } bp_metadata_t;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic            taken;
      bp_metadata_t    metadata;
   } bht_update_t;

   typedef struct packed {
      logic         valid;
      logic         taken;
      bp_metadata_t metadata;
   } bht_prediction_t;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == CTR_MAX) ? c : c + ctr_t'(1);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == '0) ? c : c - ctr_t'(1);
   endfunction

   function automatic row_t row_index(input logic [VLEN-1:0] pc, input ghr_t ghr);
      row_t r;
      r = row_t'(pc >> ROW_LSB);
      if (HIST_BITS > 0) r = r ^ row_t'(ghr);
      return r;
   endfunction

   function automatic bank_t bank_sel(input logic [VLEN-1:0] pc);
      return bank_t'((pc >> BANK_LSB) & VLEN'(INSTR_PER_FETCH-1));
   endfunction

endpackage

// File: rtl/gshare_bht_if.sv
// gshare_bht_if: fetch/backend side of the branch history table.
//   vpc_i            fetch PC to predict
//   bht_update_i     resolved branch from the backend
//   bht_prediction_o one prediction per fetch slot
//   init_done_o      table initialised, predictor live
// slave = the BHT, master = the frontend driving it.
interface gshare_bht_if;
   import gshare_bht_pkg::*;

   logic [VLEN-1:0]                       vpc_i;
   bht_update_t                           bht_update_i;
   bht_prediction_t [INSTR_PER_FETCH-1:0] bht_prediction_o;
   logic                                  init_done_o;

   modport master (output vpc_i, bht_update_i, input bht_prediction_o, init_done_o);
   modport slave  (input vpc_i, bht_update_i, output bht_prediction_o, init_done_o);
endinterface

// File: rtl/gshare_bht_bank.sv
// gshare_bht_bank: one fetch slot's counter array, NR_ROWS x CTR_BITS.
//   clk_i              clock
//   i_ra_addr/o_ra_data  sync read port A (prediction)
//   i_rb_addr/o_rb_data  sync read port B (update read stage)
//   i_we/i_waddr/i_wdata single write port (init sweep or update)
// Reads are read-first: a same-cycle write is not visible on either port.
module gshare_bht_bank
   import gshare_bht_pkg::*;
(
   input  logic clk_i,
   input  row_t i_ra_addr,
   output ctr_t o_ra_data,
   input  row_t i_rb_addr,
   output ctr_t o_rb_data,
   input  logic i_we,
   input  row_t i_waddr,
   input  ctr_t i_wdata
);

   ctr_t mem [NR_ROWS];
   ctr_t r_ra;
   ctr_t r_rb;

   always_ff @(posedge clk_i) begin
      r_ra <= mem[i_ra_addr];
      r_rb <= mem[i_rb_addr];
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_ra_data = r_ra;
   assign o_rb_data = r_rb;

endmodule

// File: rtl/gshare_bht.sv
// gshare_bht: gshare branch history table (bimodal when HIST_BITS=0).
//   clk_i, rst_ni   clock, async active-low reset
//   flush_bp_i      clear table and global history (re-runs the init sweep)
//   debug_mode_i    drop all updates
//   bus (slave)     vpc_i / bht_update_i in, bht_prediction_o / init_done_o out
// Row index = pc row bits XOR history. Updates are a two-stage
// read-modify-write; a forwarding register covers back-to-back updates to
// the same counter, whose read would otherwise miss the in-flight write.
module gshare_bht
   import gshare_bht_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_bp_i,
   input  logic        debug_mode_i,
   gshare_bht_if.slave bus
);

   init_state_e r_state, w_state_nxt;
   row_t        r_row_cnt, w_row_cnt_nxt;
   ghr_t        r_ghr;

   logic  r_pred_vld;
   row_t  r_pred_row;
   row_t  w_pred_row;
   ctr_t  w_ra_data [INSTR_PER_FETCH];
   ctr_t  w_rb_data [INSTR_PER_FETCH];

   logic  w_upd_acc;
   row_t  w_upd_row;
   bank_t w_upd_bank;
   logic  r_upd_vld, r_upd_taken;
   row_t  r_upd_row;
   bank_t r_upd_bank;
   logic  r_byp;
   ctr_t  r_byp_val;
   ctr_t  w_upd_old, w_upd_new;
   logic  w_upd_wr;

   bht_prediction_t [INSTR_PER_FETCH-1:0] w_pred;

   // ---------------- init FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= INIT;
         r_row_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_row_cnt <= w_row_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_row_cnt_nxt = r_row_cnt;
      if (flush_bp_i) begin
         w_state_nxt   = INIT;
         w_row_cnt_nxt = '0;
      end else if (r_state == INIT) begin
         // NR_ROWS is a power of two, so the counter wraps back to 0
         w_row_cnt_nxt = r_row_cnt + row_t'(1);
         if (r_row_cnt == row_t'(NR_ROWS-1)) w_state_nxt = IDLE;
      end
   end

   // ---------------- update pipe ----------------
   assign w_upd_acc  = bus.bht_update_i.valid & (r_state == IDLE) & ~debug_mode_i & ~flush_bp_i;
   assign w_upd_row  = bus.bht_update_i.metadata.index;
   assign w_upd_bank = bank_sel(bus.bht_update_i.pc);

   assign w_upd_wr  = r_upd_vld & ~flush_bp_i;  // flush discards the in-flight write
   assign w_upd_old = r_byp ? r_byp_val : w_rb_data[r_upd_bank];
   assign w_upd_new = r_upd_taken ? sat_inc(w_upd_old) : sat_dec(w_upd_old);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_upd_vld   <= 1'b0;
         r_upd_taken <= 1'b0;
         r_upd_row   <= '0;
         r_upd_bank  <= '0;
         r_byp       <= 1'b0;
         r_byp_val   <= '0;
         r_ghr       <= '0;
      end else begin
         r_upd_vld   <= w_upd_acc;
         r_upd_taken <= bus.bht_update_i.taken;
         r_upd_row   <= w_upd_row;
         r_upd_bank  <= w_upd_bank;
         // the array read this cycle is stale if the write stage hits the same counter
         r_byp       <= w_upd_wr & w_upd_acc & (r_upd_row == w_upd_row) & (r_upd_bank == w_upd_bank);
         r_byp_val   <= w_upd_new;
         if (flush_bp_i)
            r_ghr <= '0;
         else if (w_upd_acc && HIST_BITS > 0)
            r_ghr <= ghr_t'({r_ghr, bus.bht_update_i.taken});
      end
   end

   // ---------------- predict ----------------
   assign w_pred_row = row_index(bus.vpc_i, r_ghr);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pred_vld <= 1'b0;
         r_pred_row <= '0;
      end else begin
         r_pred_vld <= (r_state == IDLE);
         r_pred_row <= w_pred_row;
      end
   end

   // ---------------- banks ----------------
   for (genvar b = 0; b < INSTR_PER_FETCH; b++) begin : g_bank
      logic w_we;
      assign w_we = (r_state == INIT) | (w_upd_wr & (r_upd_bank == bank_t'(b)));

      gshare_bht_bank u_bank (
         .clk_i     (clk_i),
         .i_ra_addr (w_pred_row),
         .o_ra_data (w_ra_data[b]),
         .i_rb_addr (w_upd_row),
         .o_rb_data (w_rb_data[b]),
         .i_we      (w_we),
         .i_waddr   ((r_state == INIT) ? r_row_cnt : r_upd_row),
         .i_wdata   ((r_state == INIT) ? INIT_VAL : w_upd_new)
      );
   end

   always_comb begin
      w_pred = '0;
      for (int b = 0; b < INSTR_PER_FETCH; b++) begin
         w_pred[b].valid          = r_pred_vld;
         w_pred[b].taken          = w_ra_data[b][CTR_BITS-1];
         w_pred[b].metadata.index = r_pred_row;
      end
   end

   assign bus.bht_prediction_o = w_pred;
   assign bus.init_done_o      = (r_state == IDLE);

endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: directed + random bench for gshare_bht against a plain
// array/integer model of the counters and the global history.
module tb_gshare_bht;
   import gshare_bht_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic flush_bp_i = 1'b0;
   logic debug_mode_i = 1'b0;

   gshare_bht_if bus();

   gshare_bht dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_bp_i   (flush_bp_i),
      .debug_mode_i (debug_mode_i),
      .bus          (bus)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int m_ctr [INSTR_PER_FETCH][NR_ROWS];
   int m_ghr;
   bit m_live;

   localparam int M_MAX  = (1 << CTR_BITS) - 1;
   localparam int M_INIT = (1 << (CTR_BITS-1)) - 1;
   localparam int M_HMSK = (1 << HIST_BITS) - 1;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_flush();
      for (int b = 0; b < INSTR_PER_FETCH; b++)
         for (int r = 0; r < NR_ROWS; r++) m_ctr[b][r] = M_INIT;
      m_ghr  = 0;
      m_live = 0;
   endtask

   function automatic int peek(input int b, input int r);
      if (b == 0) return int'(dut.g_bank[0].u_bank.mem[r]);
      return int'(dut.g_bank[1].u_bank.mem[r]);
   endfunction

   // one update request for one cycle; model applies it if it would be accepted
   task automatic upd(input int b, input int r, input bit t);
      bus.bht_update_i.valid          = 1'b1;
      bus.bht_update_i.pc             = ($urandom & ~32'h2) | (32'(b) << 1);
      bus.bht_update_i.taken          = t;
      bus.bht_update_i.metadata.index = row_t'(r);
      if (m_live && !debug_mode_i && !flush_bp_i) begin
         if (t) m_ctr[b][r] = (m_ctr[b][r] == M_MAX) ? M_MAX : m_ctr[b][r] + 1;
         else   m_ctr[b][r] = (m_ctr[b][r] == 0) ? 0 : m_ctr[b][r] - 1;
         m_ghr = ((m_ghr << 1) | int'(t)) & M_HMSK;
      end
      step();
      bus.bht_update_i.valid = 1'b0;
   endtask

   task automatic drain();
      step();
      step();
   endtask

   task automatic check_table(input string tag);
      int n = 0;
      for (int b = 0; b < INSTR_PER_FETCH; b++)
         for (int r = 0; r < NR_ROWS; r++)
            if (peek(b, r) != m_ctr[b][r]) n++;
      check(tag, 64'(n), 64'd0);
   endtask

   task automatic predict(input string tag, input logic [31:0] vpc);
      int idx;
      idx = ((int'(vpc) >> ROW_LSB) & (NR_ROWS-1)) ^ m_ghr;
      bus.vpc_i = vpc;
      step();
      for (int b = 0; b < INSTR_PER_FETCH; b++) begin
         check({tag, "_vld"}, 64'(bus.bht_prediction_o[b].valid), 64'd1);
         check({tag, "_tkn"}, 64'(bus.bht_prediction_o[b].taken), 64'(m_ctr[b][idx] >= (1 << (CTR_BITS-1))));
         check({tag, "_idx"}, 64'(bus.bht_prediction_o[b].metadata.index), 64'(idx));
      end
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!bus.init_done_o && n < 2000) begin
         step();
         n++;
      end
      check(tag, 64'(n), 64'd512);
      m_live = 1;
   endtask

   function automatic logic [31:0] vpc_for_row(input int row);
      return ($urandom & 32'hFFFF_F803) | (32'((row ^ m_ghr) & (NR_ROWS-1)) << ROW_LSB);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.vpc_i        = '0;
      bus.bht_update_i = '0;
      m_flush();

      // reset state
      step();
      step();
      check("rst_done", 64'(bus.init_done_o), 64'd0);
      check("rst_vld0", 64'(bus.bht_prediction_o[0].valid), 64'd0);
      check("rst_vld1", 64'(bus.bht_prediction_o[1].valid), 64'd0);
      check("rst_ghr", 64'(dut.r_ghr), 64'd0);

      rst_ni = 1'b1;
      wait_init("init_len");
      check_table("init_tbl");
      for (int i = 0; i < 4; i++) predict("post_init", $urandom);

      // saturation up and down on row 5 bank 0
      for (int i = 0; i < 4; i++) upd(0, 5, 1'b1);
      drain();
      check("r5_up", 64'(peek(0, 5)), 64'd3);
      predict("r5_pred_t", vpc_for_row(5));
      for (int i = 0; i < 5; i++) upd(0, 5, 1'b1);
      drain();
      check("r5_sat_hi", 64'(peek(0, 5)), 64'd3);
      for (int i = 0; i < 4; i++) upd(0, 5, 1'b0);
      drain();
      check("r5_sat_lo", 64'(peek(0, 5)), 64'd0);
      predict("r5_pred_n", vpc_for_row(5));

      // back-to-back updates to one counter must not lose a step
      upd(1, 9, 1'b1);
      upd(1, 9, 1'b1);
      drain();
      check("r9_bypass", 64'(peek(1, 9)), 64'd3);
      check_table("train_tbl");

      // flush in IDLE together with an update: flush wins
      flush_bp_i = 1'b1;
      upd(0, 7, 1'b1);
      flush_bp_i = 1'b0;
      m_flush();
      check("flush_done", 64'(bus.init_done_o), 64'd0);
      wait_init("flush_len");
      check_table("flush_tbl");
      check("flush_ghr", 64'(dut.r_ghr), 64'd0);

      // history shift
      upd(0, 1, 1'b1);
      upd(1, 2, 1'b1);
      upd(0, 3, 1'b0);
      upd(1, 4, 1'b1);
      drain();
      check("ghr_1101", 64'(dut.r_ghr), 64'hD);
      predict("ghr_pred", $urandom & 32'hFFFF_F803);

      // debug mode drops updates
      debug_mode_i = 1'b1;
      for (int i = 0; i < 10; i++) upd($urandom_range(0, 1), $urandom_range(0, 31), 1'b1);
      drain();
      check_table("dbg_tbl");
      check("dbg_ghr", 64'(dut.r_ghr), 64'(m_ghr));
      predict("dbg_pred", $urandom);
      debug_mode_i = 1'b0;

      // flush restarted at INIT cycle 100
      flush_bp_i = 1'b1;
      step();
      flush_bp_i = 1'b0;
      m_flush();
      repeat (100) step();
      flush_bp_i = 1'b1;
      step();
      flush_bp_i = 1'b0;
      wait_init("reflush_len");
      check_table("reflush_tbl");

      // random traffic on a small row set so bursts collide
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0)
            upd($urandom_range(0, 1), $urandom_range(0, 7), 1'($urandom));
         else
            step();
      end
      drain();
      check_table("rnd_tbl");
      check("rnd_ghr", 64'(dut.r_ghr), 64'(m_ghr));
      for (int i = 0; i < 8; i++) predict("rnd_pred", vpc_for_row($urandom_range(0, 7)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
